clock_set_controller: RTL and testbench
=======================================

# clock_set_controller

Sequencing controller for the digital-clock timekeeper. Runs on the fast system clock, divides it down to a one-cycle 1 Hz tick enable that advances the seconds/minutes/hours counters, and owns the user time-set state machine (mode/increment buttons). Edited hours and minutes are applied to the timekeeper with a single-cycle load strobe. Sits between the debounced button inputs and the timekeeper counters.

## Interface
- CLK_HZ, default 50_000_000: system clock cycles per second. Must be ≥ 4 and even. Benches use 10.
- Clk  in  1  system clock, rising-edge active.
- reset_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  debounced, synchronous level; a rising edge advances the set mode.
- btn_inc  in  1  debounced, synchronous level; a rising edge increments the field being edited.
- cur_hours  in  5  current timekeeper hours, 0–23.
- cur_minutes  in  6  current timekeeper minutes, 0–59.
- tick_1s  out  1  one-cycle enable, once per CLK_HZ cycles, only in RUN.
- load  out  1  one-cycle strobe. Timekeeper takes load_hours/load_minutes and clears seconds.
- load_hours  out  5  edited hours register, driven continuously.
- load_minutes  out  6  edited minutes register, driven continuously.
- setting  out  2  00 = RUN, 01 = SET_HR, 10 = SET_MIN. 11 is never driven.
- blink  out  1  display blink for the field being edited. 0 in RUN.

## Operation
- Reset (async, reset_n = 0) drives:
  - state = RUN
  - prescaler = 0
  - tick_1s = 0, load = 0, blink = 0
  - load_hours = 0, load_minutes = 0
  - both button-history registers = 0
- Edge detect: edge = btn & ~btn_prev. btn_prev is registered every cycle.
  - A button held high produces exactly one edge.
  - If mode and inc edges occur in the same cycle, mode wins and inc is discarded.
- Prescaler: 0..CLK_HZ-1, width $clog2(CLK_HZ).
  - Increments every cycle in every state and wraps at CLK_HZ-1.
  - tick_1s is registered. It is 1 in the cycle after the prescaler holds CLK_HZ-1, in RUN only.
- FSM, evaluated on the edge:
  - RUN + mode edge → SET_HR. Same edge: load_hours ← cur_hours, load_minutes ← cur_minutes.
  - SET_HR + inc edge → load_hours ← (load_hours ≥ 23) ? 0 : load_hours+1.
  - SET_HR + mode edge → SET_MIN.
  - SET_MIN + inc edge → load_minutes ← (load_minutes ≥ 59) ? 0 : load_minutes+1.
  - SET_MIN + mode edge → RUN. Same edge:
    - load ← 1 for one cycle.
    - prescaler ← 0, so the first tick comes CLK_HZ cycles after load.
    - Out-of-range captured values (hours > 23, minutes > 59) are forced to 0 before load.
- No tick_1s is issued while setting ≠ 00, so the timekeeper is frozen during edit.
- blink = (prescaler ≥ CLK_HZ/2) in SET_HR/SET_MIN, otherwise 0.
- load is never asserted except on the SET_MIN → RUN transition.
- Reset in the middle of an edit discards the edit: no load, even after release.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Button edge sampled at clock edge k:
  - setting, load_hours/load_minutes and load change after edge k (visible in cycle k+1).
  - A single press has 1-cycle latency.
- Tick spacing is exactly CLK_HZ cycles in steady RUN.
- First tick after reset release appears CLK_HZ cycles after the first active edge.
- load width is exactly 1 cycle. tick_1s and load are never high in the same cycle.
- Back-to-back edges on consecutive cycles (btn low for one cycle between) are each honoured.

## Test plan
- Free run, CLK_HZ = 10: release reset → tick_1s pulses 1 cycle wide every 10 cycles; setting = 00, load = 0, blink = 0 throughout.
- Full edit, cur = 22:58:
  - mode → setting = 01, load_hours = 22, load_minutes = 58.
  - inc, inc → load_hours = 0 (23 then wrap).
  - mode → setting = 10.
  - inc → 59; inc → 0.
  - mode → load = 1 for one cycle with 0:00, setting = 00.
  - Next tick_1s 10 cycles later; no tick during edit.
- Held button: btn_inc high for 25 cycles in SET_HR → load_hours increments exactly once.
- Simultaneous mode + inc rising in SET_HR with load_hours = 5 → setting = 10, load_hours stays 5.
- Out-of-range capture: cur_hours = 27, cur_minutes = 63, mode ×3 with no inc → load pulse carries 0:00.
- Reset mid-edit: in SET_MIN, pulse reset_n low for 3 cycles →
  - setting = 00, load_hours = 0, load = 0 immediately (async).
  - After release, no load is observed and ticks resume at 10-cycle spacing.

Source files
------------

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - 1 Hz tick prescaler and hours/minutes time-set sequencer
module clock_set_controller #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       Clk,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_minutes,
   output logic       tick_1s,
   output logic       load,
   output logic [4:0] load_hours,
   output logic [5:0] load_minutes,
   output logic [1:0] setting,
   output logic       blink
);
   localparam int            PW     = $clog2(CLK_HZ);
   localparam logic [PW-1:0] P_MAX  = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_mode_prev;
   logic          r_inc_prev;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_nxt;
   logic [4:0]    r_hours;
   logic [4:0]    w_hours_nxt;
   logic [5:0]    r_minutes;
   logic [5:0]    w_minutes_nxt;
   logic          r_tick;
   logic          r_load;
   logic          r_blink;
   logic          w_tick_nxt;
   logic          w_load_nxt;
   logic          w_blink_nxt;
   logic          w_mode_edge;
   logic          w_inc_edge;

   // Mode has priority: a simultaneous inc edge is dropped.
   assign w_mode_edge = btn_mode & ~r_mode_prev;
   assign w_inc_edge  = btn_inc & ~r_inc_prev & ~w_mode_edge;

   always_comb begin
      w_state_nxt   = r_state;
      w_hours_nxt   = r_hours;
      w_minutes_nxt = r_minutes;
      w_load_nxt    = 1'b0;
      w_presc_nxt   = (r_presc == P_MAX) ? '0 : r_presc + 1'b1;
      case (r_state)
         RUN: begin
            if (w_mode_edge) begin
               w_state_nxt   = SET_HR;
               w_hours_nxt   = cur_hours;
               w_minutes_nxt = cur_minutes;
            end
         end
         SET_HR: begin
            if (w_mode_edge) begin
               w_state_nxt = SET_MIN;
            end else if (w_inc_edge) begin
               w_hours_nxt = (r_hours >= 5'd23) ? 5'd0 : r_hours + 5'd1;
            end
         end
         SET_MIN: begin
            if (w_mode_edge) begin
               // Commit the edit; restart the second so the first tick is a full period away.
               w_state_nxt   = RUN;
               w_load_nxt    = 1'b1;
               w_presc_nxt   = '0;
               w_hours_nxt   = (r_hours > 5'd23) ? 5'd0 : r_hours;
               w_minutes_nxt = (r_minutes > 6'd59) ? 6'd0 : r_minutes;
            end else if (w_inc_edge) begin
               w_minutes_nxt = (r_minutes >= 6'd59) ? 6'd0 : r_minutes + 6'd1;
            end
         end
         default: begin
            w_state_nxt = RUN;
         end
      endcase
      // Ticks only when RUN is both the current and next state, so none leaks into an edit.
      w_tick_nxt  = (r_presc == P_MAX) && (r_state == RUN) && (w_state_nxt == RUN);
      w_blink_nxt = (w_state_nxt != RUN) && (w_presc_nxt >= P_HALF);
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= RUN;
         r_mode_prev <= 1'b0;
         r_inc_prev  <= 1'b0;
         r_presc     <= '0;
         r_hours     <= 5'd0;
         r_minutes   <= 6'd0;
         r_tick      <= 1'b0;
         r_load      <= 1'b0;
         r_blink     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mode_prev <= btn_mode;
         r_inc_prev  <= btn_inc;
         r_presc     <= w_presc_nxt;
         r_hours     <= w_hours_nxt;
         r_minutes   <= w_minutes_nxt;
         r_tick      <= w_tick_nxt;
         r_load      <= w_load_nxt;
         r_blink     <= w_blink_nxt;
      end
   end

   assign tick_1s      = r_tick;
   assign load         = r_load;
   assign load_hours   = r_hours;
   assign load_minutes = r_minutes;
   assign setting      = r_state;
   assign blink        = r_blink;

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - scoreboard bench for clock_set_controller
module tb_clock_set_controller;
   localparam int N = 10;

   logic       Clk = 1'b0;
   logic       reset_n;
   logic       btn_mode;
   logic       btn_inc;
   logic [4:0] cur_hours;
   logic [5:0] cur_minutes;
   logic       tick_1s;
   logic       load;
   logic [4:0] load_hours;
   logic [5:0] load_minutes;
   logic [1:0] setting;
   logic       blink;

   clock_set_controller #(.CLK_HZ(N)) dut (
      .Clk          (Clk),
      .reset_n      (reset_n),
      .btn_mode     (btn_mode),
      .btn_inc      (btn_inc),
      .cur_hours    (cur_hours),
      .cur_minutes  (cur_minutes),
      .tick_1s      (tick_1s),
      .load         (load),
      .load_hours   (load_hours),
      .load_minutes (load_minutes),
      .setting      (setting),
      .blink        (blink)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       tick;
      logic       load;
      logic [4:0] lh;
      logic [5:0] lm;
      logic [1:0] set;
      logic       blink;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   n_loads  = 0;
   int   n_ticks  = 0;

   // Reference model: mode 0=RUN 1=SET_HR 2=SET_MIN, phase = cycles into the current second.
   int m_mode, m_hr, m_min, m_phase;
   bit m_pm, m_pi;

   task automatic model_reset();
      m_mode = 0; m_hr = 0; m_min = 0; m_phase = 0; m_pm = 0; m_pi = 0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Predict the outputs after the coming edge, then advance through it.
   task automatic cycle();
      exp_t e;
      bit   me, ie, tk, ld;
      tk = 0;
      ld = 0;
      if (!reset_n) begin
         model_reset();
      end else begin
         me = btn_mode && !m_pm;
         ie = btn_inc && !m_pi && !me;
         tk = (m_phase == N - 1) && (m_mode == 0) && !me;
         ld = (m_mode == 2) && me;
         m_phase = ld ? 0 : (m_phase + 1) % N;
         case (m_mode)
            0: if (me) begin m_mode = 1; m_hr = cur_hours; m_min = cur_minutes; end
            1: if (me) m_mode = 2; else if (ie) m_hr = (m_hr >= 23) ? 0 : m_hr + 1;
            default: begin
               if (me) begin
                  m_mode = 0;
                  if (m_hr > 23) m_hr = 0;
                  if (m_min > 59) m_min = 0;
               end else if (ie) begin
                  m_min = (m_min >= 59) ? 0 : m_min + 1;
               end
            end
         endcase
         m_pm = btn_mode;
         m_pi = btn_inc;
      end
      e.tick  = tk;
      e.load  = ld;
      e.lh    = 5'(m_hr);
      e.lm    = 6'(m_min);
      e.set   = 2'(m_mode);
      e.blink = (m_mode != 0) && (m_phase >= N / 2);
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   task automatic press_mode();
      btn_mode = 1; cycle();
      btn_mode = 0; cycle();
   endtask

   task automatic press_inc();
      btn_inc = 1; cycle();
      btn_inc = 0; cycle();
   endtask

   task automatic reset_mid(input int n);
      @(negedge Clk);
      #1;
      reset_n = 0;
      #1;
      chk("async_reset_setting", setting, 0);
      chk("async_reset_load", load, 0);
      chk("async_reset_hours", load_hours, 0);
      chk("async_reset_minutes", load_minutes, 0);
      chk("async_reset_tick", tick_1s, 0);
      chk("async_reset_blink", blink, 0);
      btn_mode = 0;
      btn_inc  = 0;
      model_reset();
      repeat (n) cycle();
      reset_n = 1;
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {tick_1s, load, load_hours, load_minutes, setting, blink};
            checks++;
            if (a.load) n_loads++;
            if (a.tick) n_ticks++;
            if (a !== e) begin
               failures++;
               $display("FAIL scoreboard t=%0t actual tick=%0b load=%0b hr=%0d min=%0d set=%0d blink=%0b expected tick=%0b load=%0b hr=%0d min=%0d set=%0d blink=%0b",
                        $time, a.tick, a.load, a.lh, a.lm, a.set, a.blink,
                        e.tick, e.load, e.lh, e.lm, e.set, e.blink);
            end
         end
      end
   end

   initial begin : stimulus
      int loads_before;
      reset_n     = 0;
      btn_mode    = 0;
      btn_inc     = 0;
      cur_hours   = 0;
      cur_minutes = 0;
      model_reset();
      repeat (3) cycle();
      reset_n = 1;

      repeat (35) cycle();
      chk("free_run_ticks", n_ticks, 3);

      cur_hours = 22; cur_minutes = 58;
      press_mode();
      press_inc(); press_inc();
      press_mode();
      press_inc(); press_inc();
      press_mode();
      repeat (15) cycle();
      chk("full_edit_one_load", n_loads, 1);

      press_mode();
      btn_inc = 1;
      repeat (25) cycle();
      btn_inc = 0;
      cycle();
      press_mode(); press_mode();

      cur_hours = 5; cur_minutes = 10;
      press_mode();
      btn_mode = 1; btn_inc = 1; cycle();
      btn_mode = 0; btn_inc = 0; cycle();
      press_mode();
      repeat (4) cycle();

      cur_hours = 27; cur_minutes = 63;
      press_mode(); press_mode(); press_mode();
      repeat (4) cycle();

      cur_hours = 9; cur_minutes = 30;
      press_mode(); press_mode();
      repeat (3) cycle();
      loads_before = n_loads;
      reset_mid(3);
      repeat (25) cycle();
      chk("no_load_after_reset", n_loads, loads_before);

      repeat (4000) begin
         if ($urandom_range(0, 15) == 0) begin
            cur_hours   = 5'($urandom_range(0, 31));
            cur_minutes = 6'($urandom_range(0, 63));
         end
         btn_mode = ($urandom_range(0, 5) == 0);
         btn_inc  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) reset_mid($urandom_range(1, 4));
         else cycle();
      end
      btn_mode = 0;
      btn_inc  = 0;
      repeat (3) @(negedge Clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
